idct4_pipe: RTL and testbench
=============================

// Module: idct4_pipe
// PURPOSE
//  Inverse of the 4-point integer DCT used in the approximate-DCT datapath; forward kernel is
//  64/80/36 (y1=80*b0+36*b1, y3=36*b0-80*b1, y0/y2=64*(a0+/-a1)).
//  Accepts one block of 4 signed coefficients per beat and returns 4 reconstructed 8-bit unsigned
//  samples after a 3-stage pipeline. Sits on the decode/verification side of the DCT datapath.
//  Valid/ready on both sides.
// PARAMETERS
//  IN_W   16  coefficient width (two's complement), matches forward-DCT output width
//  SHIFT  14  final rounding right-shift; 2^14 ~ forward*inverse gain (64*64*4)
//  OUT_W  8   sample width, unsigned, clamped to [0, 2^OUT_W-1]
//  ACC_W  26  internal accumulator width (IN_W+10); no intermediate overflow for any input
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      coefficient block valid
//  in_ready   out  1      block accepted on clk edge when in_valid & in_ready
//  c0..c3     in   IN_W   signed coefficients Y0..Y3 (DC, odd1, even2, odd3)
//  out_valid  out  1      sample block valid; held with data stable until out_ready
//  out_ready  in   1      downstream accepts block
//  x0..x3     out  OUT_W  reconstructed samples
//  out_sat    out  1      1 if any of x0..x3 of this block was clamped
//  busy       out  1      OR of all stage valid bits
// BEHAVIOUR
//  Reset (async assert, sync deassert by system): all stage valids=0, out_valid=0, x0..x3=0,
//   out_sat=0, busy=0. In-flight blocks are discarded; no partial output after reset.
//  Global enable en = ~out_valid | out_ready; in_ready = en (combinational, no path from in_valid).
//   en=0 freezes every stage register, including valids; bubbles are not squeezed.
//  S1 (on accept): e0=64*(c0+c2), e1=64*(c0-c2), p80_1=80*c1, p36_1=36*c1, p80_3=80*c3, p36_3=36*c3.
//   Constant multiplies are shift-add only: 64=<<6, 80=(<<6)+(<<4), 36=(<<5)+(<<2). All sign-extended to ACC_W.
//  S2: o0=p80_1+p36_3, o1=p36_1-p80_3; r0=e0+o0, r1=e1+o1, r2=e1-o1, r3=e0-o0.
//  S3: xi = (ri + 2^(SHIFT-1)) >>> SHIFT (arithmetic); clamp <0 ->0, >2^OUT_W-1 -> 2^OUT_W-1;
//   out_sat = OR of the four clamp events; out_valid=1.
//  Latency: accept at edge N -> out_valid high after edge N+3 when en stays 1. Throughput 1 block/clk.
//  Simultaneous out handshake and new accept in same cycle: legal; full pipeline sustains 1/clk.
//  out_valid=1 & out_ready=0: x*, out_sat, out_valid hold; in_ready=0; S1/S2 contents held.
//  in_valid low: stage valid bit shifts in 0; data regs may update (don't care) but must not raise out_valid.
//  Output register is the only output state; x*/out_sat change only on edges where en=1.
// TESTING
//  T1 DC: c=(2560,0,0,0) -> x=(10,10,10,10), out_sat=0, out_valid 3 clks after accept.
//  T2 round-trip: c=(6400,-2760,0,-280) (fwd of 10,20,30,40) -> x=(11,20,30,39), out_sat=0.
//  T3 clamp: c=(32767,0,32767,0) -> x=(255,0,0,255), out_sat=1; c=(-2560,0,0,0) -> x=(0,0,0,0), out_sat=1.
//  T4 backpressure: stream 5 blocks with in_valid=1, hold out_ready=0 for 4 clks mid-stream ->
//   in_ready=0 during stall, out data stable, all 5 blocks delivered in order, none duplicated/lost.
//  T5 full throughput: 16 back-to-back random blocks, out_ready=1 -> 16 outputs on 16 consecutive
//   clks matching the bit-exact model above.
//  T6 reset mid-op: assert rst_n=0 with 3 blocks in flight -> out_valid, busy, x*, out_sat go 0
//   immediately (async); after release no stale block is emitted; next block has 3-clk latency.

Source files
------------

// File: rtl/idct4_pipe.sv
// ----------------------------------------------------------------------------
// idct4_pipe
//   Inverse 4-point integer DCT matching the 64/80/36 forward kernel.
//   Each accepted beat carries one block of four signed coefficients.
//   The block leaves as four clamped unsigned samples, three clocks later.
//
//   Pipeline, one register rank per step:
//     capture : register the accepted coefficients
//     S1      : even sums (64*(c0+/-c2)) and odd partial products
//               (80*c1, 36*c1, 80*c3, 36*c3), all shift-add
//     S2      : butterfly  r0=e0+o0  r1=e1+o1  r2=e1-o1  r3=e0-o0
//     S3      : round, arithmetic shift, clamp (output register)
//
//   A single global enable (~out_valid | out_ready) advances every rank
//   together. Bubbles are therefore not squeezed out.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   coefficient block valid
//   in_ready   block accepted on an edge where in_valid & in_ready
//   c0..c3     signed coefficients Y0..Y3 (DC, odd1, even2, odd3)
//   out_valid  sample block valid; held stable until out_ready
//   out_ready  downstream accepts the block
//   x0..x3     reconstructed unsigned samples
//   out_sat    at least one sample of this block was clamped
//   busy       any pipeline rank holds a valid block
// ----------------------------------------------------------------------------
module idct4_pipe #(
   parameter int IN_W  = 16,
   parameter int SHIFT = 14,
   parameter int OUT_W = 8,
   parameter int ACC_W = 26
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  c0,
   input  logic [IN_W-1:0]  c1,
   input  logic [IN_W-1:0]  c2,
   input  logic [IN_W-1:0]  c3,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] x0,
   output logic [OUT_W-1:0] x1,
   output logic [OUT_W-1:0] x2,
   output logic [OUT_W-1:0] x3,
   output logic             out_sat,
   output logic             busy
);

   // Rounding offset 2^(SHIFT-1), and the largest representable sample.
   localparam logic signed [ACC_W-1:0] RND  = {{(ACC_W-1){1'b0}}, 1'b1} << (SHIFT-1);
   localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

   function automatic logic signed [ACC_W-1:0] sext(input logic [IN_W-1:0] v);
      sext = {{(ACC_W-IN_W){v[IN_W-1]}}, v};
   endfunction

   // Returns {clamped, sample}.
   function automatic logic [OUT_W:0] round_clamp(input logic signed [ACC_W-1:0] r);
      logic signed [ACC_W-1:0] t;
      t = (r + RND) >>> SHIFT;
      if (t[ACC_W-1])
         round_clamp = {1'b1, {OUT_W{1'b0}}};
      else if (t > MAXV)
         round_clamp = {1'b1, {OUT_W{1'b1}}};
      else
         round_clamp = {1'b0, t[OUT_W-1:0]};
   endfunction

   // ---------------------------------------------------------------- control
   logic en;
   logic v0, v1, v2;

   // No path from in_valid: readiness depends only on the output register.
   assign en       = ~out_valid | out_ready;
   assign in_ready = en;
   assign busy     = v0 | v1 | v2 | out_valid;

   // ------------------------------------------------------------ data ranks
   logic [IN_W-1:0]         k0, k1, k2, k3;
   logic signed [ACC_W-1:0] e0, e1, p80_1, p36_1, p80_3, p36_3;
   logic signed [ACC_W-1:0] r0, r1, r2, r3;

   // S1 combinational: constant multiplies as shift-add on sign-extended inputs.
   logic signed [ACC_W-1:0] k0_x, k1_x, k2_x, k3_x;
   logic signed [ACC_W-1:0] e0_d, e1_d, p80_1_d, p36_1_d, p80_3_d, p36_3_d;

   assign k0_x    = sext(k0);
   assign k1_x    = sext(k1);
   assign k2_x    = sext(k2);
   assign k3_x    = sext(k3);
   assign e0_d    = (k0_x + k2_x) <<< 6;
   assign e1_d    = (k0_x - k2_x) <<< 6;
   assign p80_1_d = (k1_x <<< 6) + (k1_x <<< 4);
   assign p36_1_d = (k1_x <<< 5) + (k1_x <<< 2);
   assign p80_3_d = (k3_x <<< 6) + (k3_x <<< 4);
   assign p36_3_d = (k3_x <<< 5) + (k3_x <<< 2);

   // S2 combinational: odd terms and butterfly.
   logic signed [ACC_W-1:0] o0, o1;

   assign o0 = p80_1 + p36_3;
   assign o1 = p36_1 - p80_3;

   // S3 combinational: round, shift and clamp each lane.
   logic [OUT_W:0] rc0, rc1, rc2, rc3;

   assign rc0 = round_clamp(r0);
   assign rc1 = round_clamp(r1);
   assign rc2 = round_clamp(r2);
   assign rc3 = round_clamp(r3);

   // NOTE: datapath ranks carry no reset; the valid bits alone decide whether
   // their contents mean anything, so resetting them would only add fan-out.
   always_ff @(posedge clk) begin
      if (en) begin
         if (in_valid) begin
            k0 <= c0;
            k1 <= c1;
            k2 <= c2;
            k3 <= c3;
         end
         if (v0) begin
            e0    <= e0_d;
            e1    <= e1_d;
            p80_1 <= p80_1_d;
            p36_1 <= p36_1_d;
            p80_3 <= p80_3_d;
            p36_3 <= p36_3_d;
         end
         if (v1) begin
            r0 <= e0 + o0;
            r1 <= e1 + o1;
            r2 <= e1 - o1;
            r3 <= e0 - o0;
         end
      end
   end

   // Valid chain and the output register; these are visible state, so they reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v0        <= 1'b0;
         v1        <= 1'b0;
         v2        <= 1'b0;
         out_valid <= 1'b0;
         x0        <= '0;
         x1        <= '0;
         x2        <= '0;
         x3        <= '0;
         out_sat   <= 1'b0;
      end else if (en) begin
         v0        <= in_valid;
         v1        <= v0;
         v2        <= v1;
         out_valid <= v2;
         // Samples only move when a real block arrives, so bubbles never
         // disturb the last delivered values.
         if (v2) begin
            x0      <= rc0[OUT_W-1:0];
            x1      <= rc1[OUT_W-1:0];
            x2      <= rc2[OUT_W-1:0];
            x3      <= rc3[OUT_W-1:0];
            out_sat <= rc0[OUT_W] | rc1[OUT_W] | rc2[OUT_W] | rc3[OUT_W];
         end
      end
   end

endmodule

// File: tb/tb_idct4_pipe.sv
// ----------------------------------------------------------------------------
// tb_idct4_pipe
//   Self-checking bench for idct4_pipe.
//   - A table of directed blocks with hand-computed samples, checked one at a
//     time for latency and value.
//   - A backpressure stream and a full-rate random stream, both scored against
//     an integer model of the inverse transform.
//   - An asynchronous reset asserted while blocks are in flight.
// ----------------------------------------------------------------------------
module tb_idct4_pipe;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] c0, c1, c2, c3;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  x0, x1, x2, x3;
   logic        out_sat;
   logic        busy;

   idct4_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .c0        (c0),
      .c1        (c1),
      .c2        (c2),
      .c3        (c3),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .x0        (x0),
      .x1        (x1),
      .x2        (x2),
      .x3        (x3),
      .out_sat   (out_sat),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d", name, act, exp);
   endtask

   // {sat, x0, x1, x2, x3} from {c0, c1, c2, c3}, plain integer arithmetic.
   function automatic logic [32:0] model(input logic [63:0] b);
      longint a0, a1, a2, a3, e0, e1, o0, o1, t;
      longint r [4];
      logic [32:0] res;
      a0 = longint'($signed(b[63:48]));
      a1 = longint'($signed(b[47:32]));
      a2 = longint'($signed(b[31:16]));
      a3 = longint'($signed(b[15:0]));
      e0 = 64 * (a0 + a2);
      e1 = 64 * (a0 - a2);
      o0 = 80 * a1 + 36 * a3;
      o1 = 36 * a1 - 80 * a3;
      r[0] = e0 + o0;
      r[1] = e1 + o1;
      r[2] = e1 - o1;
      r[3] = e0 - o0;
      res = '0;
      for (int i = 0; i < 4; i++) begin
         t = (r[i] + 8192) >>> 14;
         if (t < 0) begin
            res[32] = 1'b1;
            res[31-8*i -: 8] = 8'd0;
         end else if (t > 255) begin
            res[32] = 1'b1;
            res[31-8*i -: 8] = 8'd255;
         end else begin
            res[31-8*i -: 8] = t[7:0];
         end
      end
      return res;
   endfunction

   typedef struct {
      string       name;
      logic [63:0] c;
      logic [31:0] x;
      logic        sat;
   } vec_t;

   function automatic vec_t mk(input string n, input int a0, input int a1, input int a2,
                               input int a3, input int y0, input int y1, input int y2,
                               input int y3, input bit s);
      vec_t v;
      v.name = n;
      v.c    = {16'(a0), 16'(a1), 16'(a2), 16'(a3)};
      v.x    = {8'(y0), 8'(y1), 8'(y2), 8'(y3)};
      v.sat  = s;
      return v;
   endfunction

   vec_t        tbl [8];
   logic [63:0] blk [16];

   task automatic set_c(input logic [63:0] b);
      {c0, c1, c2, c3} = b;
   endtask

   // ------------------------------------------------------------- scoreboard
   bit          mon_en = 1'b0;
   logic [32:0] exp_q [$];
   int          rx_cnt;
   int          cyc = 0;
   int          first_rx;
   int          last_rx;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (mon_en) begin
         if (in_valid && in_ready) exp_q.push_back(model({c0, c1, c2, c3}));
         if (out_valid && out_ready) begin
            check("out_expected", longint'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               check($sformatf("stream_blk%0d", rx_cnt), {out_sat, x0, x1, x2, x3},
                     exp_q.pop_front());
            end
            if (first_rx < 0) first_rx = cyc;
            last_rx = cyc;
            rx_cnt++;
         end
      end
   end

   task automatic mon_start();
      exp_q.delete();
      rx_cnt   = 0;
      first_rx = -1;
      last_rx  = -1;
      mon_en   = 1'b1;
   endtask

   // Present blk[0..n-1] back to back; each is held until accepted.
   task automatic stream(input int n);
      bit acc;
      int guard;
      for (int i = 0; i < n; i++) begin
         set_c(blk[i]);
         in_valid = 1'b1;
         acc      = 1'b0;
         guard    = 0;
         while (!acc && guard < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
         end
         if (!acc) check($sformatf("accept_timeout_blk%0d", i), acc, 1);
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((busy || exp_q.size() != 0) && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({name, "_drained"}, longint'(!busy && exp_q.size() == 0), 1);
   endtask

   // Single block on an idle pipeline: accept, latency, samples, sat flag.
   task automatic apply_vec(input vec_t v);
      int lat;
      set_c(v.c);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      check({v.name, "_in_ready"}, in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check({v.name, "_no_early_valid"}, out_valid, 0);
      lat = 0;
      while (!out_valid && lat < 8) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({v.name, "_latency"}, lat, 3);
      check({v.name, "_x"}, {x0, x1, x2, x3}, v.x);
      check({v.name, "_sat"}, out_sat, v.sat);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [32:0] snap;
      int          n;
      int          stale;

      tbl[0] = mk("dc",        2560,     0,     0,    0,  10, 10, 10,  10, 1'b0);
      tbl[1] = mk("roundtrip", 6400, -2760,     0, -280,  11, 20, 30,  39, 1'b0);
      tbl[2] = mk("clamp_hi", 32767,     0, 32767,    0, 255,  0,  0, 255, 1'b1);
      tbl[3] = mk("clamp_neg", -2560,    0,     0,    0,   0,  0,  0,   0, 1'b1);
      tbl[4] = mk("odd1",         0,  1000,     0,    0,   5,  2,  0,   0, 1'b1);
      tbl[5] = mk("odd3",         0,     0,     0, 1000,   2,  0,  5,   0, 1'b1);
      tbl[6] = mk("even2",        0,     0,  2560,    0,  10,  0,  0,  10, 1'b1);
      tbl[7] = mk("zero",         0,     0,     0,    0,   0,  0,  0,   0, 1'b0);

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      set_c('0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_x", {x0, x1, x2, x3}, 0);
      check("rst_sat", out_sat, 0);
      check("rst_in_ready", in_ready, 1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed table: one block at a time.
      for (int i = 0; i < 8; i++) apply_vec(tbl[i]);

      // Backpressure: five blocks, output stalled four clocks mid-stream.
      for (int i = 0; i < 5; i++) blk[i] = tbl[i].c;
      out_ready = 1'b1;
      mon_start();
      fork
         stream(5);
         begin
            n = 0;
            while (!out_valid && n < 20) begin
               @(posedge clk);
               #1;
               n++;
            end
            check("bp_first_out", out_valid, 1);
            out_ready = 1'b0;
            snap = {out_sat, x0, x1, x2, x3};
            for (int k = 0; k < 4; k++) begin
               @(negedge clk);
               check($sformatf("bp_in_ready_c%0d", k), in_ready, 0);
               check($sformatf("bp_hold_valid_c%0d", k), out_valid, 1);
               check($sformatf("bp_hold_data_c%0d", k), {out_sat, x0, x1, x2, x3}, snap);
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      wait_drain("bp");
      check("bp_rx_count", rx_cnt, 5);
      mon_en = 1'b0;

      // Full throughput: sixteen random blocks, no backpressure.
      for (int i = 0; i < 16; i++) blk[i] = {$urandom(), $urandom()};
      out_ready = 1'b1;
      mon_start();
      stream(16);
      wait_drain("thru");
      check("thru_rx_count", rx_cnt, 16);
      check("thru_consecutive", last_rx - first_rx, 15);
      mon_en = 1'b0;

      // Reset with blocks in flight.
      out_ready = 1'b1;
      set_c(tbl[0].c);
      in_valid = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("mid_busy_before", busy, 1);
      check("mid_valid_before", out_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_x", {x0, x1, x2, x3}, 0);
      check("mid_rst_sat", out_sat, 0);
      @(posedge clk);
      #3;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      stale = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      check("mid_no_stale", stale, 0);
      @(posedge clk);
      #1;
      apply_vec(tbl[1]);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
